// File: rtl/router_src_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_src_tx
// Purpose  : Packet source for the 1x3 router. Buffers host payload bytes and
//            frames them as header / payload / parity, stalling on busy.
// Revision : 1.0 - initial release
// ============================================================================
module router_src_tx #(
    parameter int DEPTH    = 64,
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld_wr,
    input  logic [7:0] ld_data,
    output logic       ld_full,
    input  logic       start,
    input  logic [1:0] start_addr,
    input  logic [5:0] start_len,
    output logic       ready,
    output logic       cmd_err,
    output logic       done,
    output logic       pkt_err,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    input  logic       busy,
    input  logic       error
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WCNT_W = (ERR_WAIT < 1) ? 1 : $clog2(ERR_WAIT + 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_WCNT_W-1:0] c_ERR_WAIT = c_WCNT_W'(ERR_WAIT);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_HDR     = 3'd1;
    localparam logic [2:0] c_PAYLOAD = 3'd2;
    localparam logic [2:0] c_PARITY  = 3'd3;
    localparam logic [2:0] c_ERRWAIT = 3'd4;

    // Payload FIFO
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full, w_push, w_pop;
    logic [7:0]         w_head;

    // Framer state
    logic [2:0]          r_state, w_state_n;
    logic [7:0]          r_data, w_data_n;
    logic                r_valid, w_valid_n;
    logic                r_ready, w_ready_n;
    logic                r_cmd_err, w_cmd_err_n;
    logic                r_done, w_done_n;
    logic                r_pkt_err, w_pkt_err_n;
    logic [7:0]          r_parity, w_parity_n;
    logic [5:0]          r_len, w_len_n;
    logic [5:0]          r_rem, w_rem_n;
    logic                r_sticky, w_sticky_n;
    logic [c_WCNT_W-1:0] r_wcnt, w_wcnt_n;
    logic                w_cmd_bad;

    assign w_full = (r_count == c_DEPTH);
    assign w_push = ld_wr && !w_full;
    assign w_head = r_mem[r_rd_ptr];

    assign w_cmd_bad = (start_addr == 2'd3) || (start_len == 6'd0) ||
                       (32'(start_len) > 32'(r_count)) ||
                       (32'(start_len) > 32'(MAX_LEN));

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= ld_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_data_n    = r_data;
        w_valid_n   = r_valid;
        w_ready_n   = r_ready;
        w_cmd_err_n = 1'b0;
        w_done_n    = 1'b0;
        w_pkt_err_n = r_pkt_err;
        w_parity_n  = r_parity;
        w_len_n     = r_len;
        w_rem_n     = r_rem;
        w_sticky_n  = r_sticky;
        w_wcnt_n    = r_wcnt;
        w_pop       = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_ready_n = 1'b1;
                w_valid_n = 1'b0;
                w_data_n  = 8'd0;
                if (start) begin
                    if (w_cmd_bad) begin
                        w_cmd_err_n = 1'b1;
                    end else begin
                        w_len_n    = start_len;
                        w_ready_n  = 1'b0;
                        w_data_n   = {start_len, start_addr};
                        w_parity_n = {start_len, start_addr};
                        w_valid_n  = 1'b1;
                        w_state_n  = c_HDR;
                    end
                end
            end
            c_HDR: begin
                if (!busy) begin
                    w_data_n   = w_head;
                    w_pop      = 1'b1;
                    w_parity_n = r_parity ^ w_head;
                    w_rem_n    = r_len - 6'd1;
                    w_state_n  = c_PAYLOAD;
                end
            end
            c_PAYLOAD: begin
                if (!busy) begin
                    if (r_rem != 6'd0) begin
                        w_data_n   = w_head;
                        w_pop      = 1'b1;
                        w_parity_n = r_parity ^ w_head;
                        w_rem_n    = r_rem - 6'd1;
                    end else begin
                        w_data_n  = r_parity;
                        w_valid_n = 1'b0;
                        w_state_n = c_PARITY;
                    end
                end
            end
            c_PARITY: begin
                if (!busy) begin
                    w_data_n   = 8'd0;
                    w_valid_n  = 1'b0;
                    w_sticky_n = 1'b0;
                    w_wcnt_n   = c_ERR_WAIT;
                    w_state_n  = c_ERRWAIT;
                end
            end
            c_ERRWAIT: begin
                // Error seen on the final window cycle still counts for this packet
                w_sticky_n = r_sticky | error;
                if (r_wcnt == '0) begin
                    w_done_n    = 1'b1;
                    w_pkt_err_n = r_sticky | error;
                    w_ready_n   = 1'b1;
                    w_state_n   = c_IDLE;
                end else begin
                    w_wcnt_n = r_wcnt - c_WCNT_W'(1);
                end
            end
            default: w_state_n = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
            r_cmd_err <= 1'b0;
            r_done    <= 1'b0;
            r_pkt_err <= 1'b0;
            r_parity  <= 8'd0;
            r_len     <= 6'd0;
            r_rem     <= 6'd0;
            r_sticky  <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_ready   <= w_ready_n;
            r_cmd_err <= w_cmd_err_n;
            r_done    <= w_done_n;
            r_pkt_err <= w_pkt_err_n;
            r_parity  <= w_parity_n;
            r_len     <= w_len_n;
            r_rem     <= w_rem_n;
            r_sticky  <= w_sticky_n;
            r_wcnt    <= w_wcnt_n;
        end
    end

    assign ld_full   = w_full;
    assign ready     = r_ready;
    assign cmd_err   = r_cmd_err;
    assign done      = r_done;
    assign pkt_err   = r_pkt_err;
    assign data_in   = r_data;
    assign pkt_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/router_src_tx.md
Name: router_src_tx

Overview:
Synthesizable packet transmitter that drives the source (input) side of the 1x3 router: data_in, pkt_valid, busy, error.
- A host preloads payload bytes into an internal FIFO, then issues a start command with destination address and length.
- The block frames the packet as header, payload, then parity, and stalls on busy.
- After the parity byte it samples the router's error flag and reports per-packet status.

Parameters:
DEPTH, 64, payload FIFO depth in bytes (power of 2, must be at least MAX_LEN)
MAX_LEN, 63, maximum payload length; the header length field is 6 bits
ERR_WAIT, 3, cycles after parity acceptance during which error is sampled

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
ld_wr  in  1  push ld_data into the payload FIFO
ld_data  in  8  payload byte
ld_full  out  1  FIFO holds DEPTH bytes
start  in  1  request to send one packet (sampled only while ready=1)
start_addr  in  2  destination port, 0..2
start_len  in  6  payload length, 1..MAX_LEN
ready  out  1  idle, start will be accepted
cmd_err  out  1  1-cycle pulse: start rejected
done  out  1  1-cycle pulse: packet finished
pkt_err  out  1  valid with done: error seen during the ERR_WAIT window
data_in  out  8  byte to router
pkt_valid  out  1  high for header and payload, low for parity
busy  in  1  router stall
error  in  1  router parity-error flag

Behaviour:
- **Reset** (synchronous, active-high): data_in=0, pkt_valid=0, ready=1, done=0, pkt_err=0, cmd_err=0, FIFO emptied (ld_full=0), state IDLE.
  - Reset mid-packet aborts immediately. A truncated packet on the router side is accepted behaviour.
- **All outputs registered.** A byte on data_in is "accepted" at a posedge where busy==0. While busy==1, data_in and pkt_valid hold their values.
- **FIFO**
  - Push when ld_wr && !ld_full. ld_wr while full is ignored; contents are unchanged.
  - Pop happens only on payload acceptance. Simultaneous push and pop leaves the count unchanged.
  - Loading is permitted in any state except reset, so the next packet may be preloaded during transmission.
- **States:** IDLE, HDR, PAYLOAD, PARITY, ERRWAIT.
- **IDLE**
  - ready=1, pkt_valid=0, data_in=0.
  - On start, the command is rejected when any of the following holds: start_addr==3, start_len==0, or start_len > FIFO count.
  - Reject: cmd_err pulses one cycle later, the state stays IDLE, and the FIFO is untouched.
  - Accept: latch addr and len, ready goes to 0, go to HDR.
    - On the next edge: data_in={len,addr}, pkt_valid=1, parity register = header.
- **HDR**
  - On acceptance, drive FIFO head on data_in with pkt_valid=1, pop, XOR into parity, remaining count = len-1.
  - Go to PAYLOAD.
- **PAYLOAD**
  - On acceptance, if remaining > 0: next byte, pop, XOR, decrement.
  - If remaining == 0: data_in = parity register, pkt_valid=0, go to PARITY.
- **PARITY**
  - On acceptance: data_in=0, pkt_valid=0, clear sticky error flag, load counter = ERR_WAIT, go to ERRWAIT.
- **ERRWAIT**
  - Each cycle, sticky |= error; counter decrements.
  - When the counter reaches 0: done=1 for one cycle, pkt_err = sticky (held until the next done), ready=1, go to IDLE.
- **Latency:** header appears one cycle after start is accepted. With busy=0 throughout, start to done = len + 3 + ERR_WAIT cycles.
- **Other rules**
  - start outside IDLE is ignored; no cmd_err is generated.
  - error outside ERRWAIT is ignored.
  - Parity is the XOR of the header and all payload bytes.

Test Plan:
1. Load 0x11,0x22,0x33; start addr=1 len=3; busy=0 -> data_in sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; done 1+ERR_WAIT cycles after parity acceptance; pkt_err=0; FIFO empty.
2. Same packet with busy=1 for 2 cycles while the header is driven -> header 0x0D held 3 cycles, remaining sequence unchanged, parity still 0x0D.
3. start addr=3 (and separately len=5 with 2 bytes loaded) -> cmd_err single pulse, ready stays 1, pkt_valid never asserts, FIFO count unchanged.
4. Push 64 bytes -> ld_full=1; 65th push ignored; start addr=2 len=63 sends 63 bytes with header 0xFE; 1 byte remains; ld_full drops after the first pop.
5. Pulse error for 1 cycle during ERRWAIT -> done with pkt_err=1; next clean packet -> pkt_err=0.
6. Assert reset in PAYLOAD after 2 bytes -> next cycle pkt_valid=0, data_in=0, ready=1, FIFO empty, no done pulse.
